// File: rtl/adder32_rr_scheduler.sv
// Two-requester scheduler sharing one 32-bit carry-lookahead adder (IDLE/CALC/HOLD).
// Define ADDER32_SCHED_FIXED_PRIO_EN to make requester 0 win every tie instead of round-robin.

module carry_lookahead_adder32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        c_i,
    output logic [31:0] sum_o,
    output logic        c_o
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic        g_acc;
    logic        p_acc;
    logic        c_grp;

    // 4-bit lookahead groups; each bit carry is expanded from the group's incoming carry
    always_comb begin
        g     = a_i & b_i;
        p     = a_i ^ b_i;
        c     = '0;
        c[0]  = c_i;
        c_grp = c_i;
        g_acc = 1'b0;
        p_acc = 1'b1;
        for (int unsigned grp = 0; grp < 8; grp++) begin
            g_acc = 1'b0;
            p_acc = 1'b1;
            for (int unsigned i = 0; i < 4; i++) begin
                g_acc = g[grp*4+i] | (p[grp*4+i] & g_acc);
                p_acc = p_acc & p[grp*4+i];
                c[grp*4+i+1] = g_acc | (p_acc & c_grp);
            end
            c_grp = g_acc | (p_acc & c_grp);
        end
        sum_o = p ^ c[31:0];
        c_o   = c[32];
    end

endmodule

module adder32_rr_scheduler (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [31:0] req0_a_i,
    input  logic [31:0] req0_b_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [31:0] req1_a_i,
    input  logic [31:0] req1_b_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [32:0] rsp_sum_o,
    output logic        rsp_id_o
);

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [32:0] rsp_sum_q, rsp_sum_d;
    logic        rsp_id_q, rsp_id_d;
    logic        op_id_q, op_id_d;
    logic        grant1;
    logic [31:0] add_sum;
    logic        add_co;

    carry_lookahead_adder32 u_add (
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .c_i   (1'b0),
        .sum_o (add_sum),
        .c_o   (add_co)
    );

`ifdef ADDER32_SCHED_FIXED_PRIO_EN
    always_comb grant1 = req1_valid_i & ~req0_valid_i;
`else
    logic last_q, last_d;

    // last_q holds the index of the most recent grant; the other requester wins a tie
    always_comb grant1 = req1_valid_i & (~req0_valid_i | ~last_q);
`endif

    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_id_d      = op_id_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_id_d     = rsp_id_q;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
`ifndef ADDER32_SCHED_FIXED_PRIO_EN
        last_d       = last_q;
`endif
        case (state_q)
            IDLE: begin
                if ((req0_valid_i | req1_valid_i) && !rst_i) begin
                    req0_ready_o = ~grant1;
                    req1_ready_o = grant1;
                    op_a_d       = grant1 ? req1_a_i : req0_a_i;
                    op_b_d       = grant1 ? req1_b_i : req0_b_i;
                    op_id_d      = grant1;
`ifndef ADDER32_SCHED_FIXED_PRIO_EN
                    last_d       = grant1;
`endif
                    state_d      = CALC;
                end
            end
            CALC: begin
                rsp_sum_d = {add_co, add_sum};
                rsp_id_d  = op_id_q;
                state_d   = HOLD;
            end
            HOLD: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_id_q   <= 1'b0;
            rsp_sum_q <= '0;
            rsp_id_q  <= 1'b0;
`ifndef ADDER32_SCHED_FIXED_PRIO_EN
            last_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            op_id_q   <= op_id_d;
            rsp_sum_q <= rsp_sum_d;
            rsp_id_q  <= rsp_id_d;
`ifndef ADDER32_SCHED_FIXED_PRIO_EN
            last_q    <= last_d;
`endif
        end
    end

    assign rsp_valid_o = (state_q == HOLD);
    assign rsp_sum_o   = rsp_sum_q;
    assign rsp_id_o    = rsp_id_q;

endmodule

// File: tb/tb_adder32_rr_scheduler.sv
// Directed self-checking bench for adder32_rr_scheduler (honours ADDER32_SCHED_FIXED_PRIO_EN).

module tb_adder32_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1, r0, r1;
    logic [31:0] a0, b0, a1, b1;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [32:0] rsp_sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adder32_rr_scheduler dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_valid_i (v0),
        .req0_ready_o (r0),
        .req0_a_i     (a0),
        .req0_b_i     (b0),
        .req1_valid_i (v1),
        .req1_ready_o (r1),
        .req1_a_i     (a1),
        .req1_b_i     (b1),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_sum_o    (rsp_sum),
        .rsp_id_o     (rsp_id)
    );

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in IDLE with inputs already driven; runs grant -> CALC -> HOLD -> IDLE.
    task automatic txn(input string tag, input logic exp_id, input logic [32:0] exp_sum);
        #1;
        chk({tag, "_r0"}, {32'd0, r0}, {32'd0, ~exp_id});
        chk({tag, "_r1"}, {32'd0, r1}, {32'd0, exp_id});
        tick();
        v0 = 1'b0; v1 = 1'b0;
        #1;
        chk({tag, "_calc_valid"}, {32'd0, rsp_valid}, 33'd0);
        chk({tag, "_calc_rdy"}, {31'd0, r0, r1}, 33'd0);
        tick();
        chk({tag, "_valid"}, {32'd0, rsp_valid}, 33'd1);
        chk({tag, "_sum"}, rsp_sum, exp_sum);
        chk({tag, "_id"}, {32'd0, rsp_id}, {32'd0, exp_id});
        tick();
        chk({tag, "_idle_valid"}, {32'd0, rsp_valid}, 33'd0);
    endtask

    initial begin
        logic exp_id;
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b1;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        tick();
        v0 = 1'b1; v1 = 1'b1;
        #1;
        chk("rst_r0", {32'd0, r0}, 33'd0);
        chk("rst_r1", {32'd0, r1}, 33'd0);
        chk("rst_valid", {32'd0, rsp_valid}, 33'd0);
        chk("rst_sum", rsp_sum, 33'd0);
        chk("rst_id", {32'd0, rsp_id}, 33'd0);
        v0 = 1'b0; v1 = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        v0 = 1'b1; a0 = 32'h29AF_2430; b0 = 32'h7A1B_9ABC;
        txn("single0", 1'b0, 33'h0_A3CA_BEEC);

        v1 = 1'b1; a1 = 32'h8051_9860; b1 = 32'h8086_BA3E;
        txn("carry1", 1'b1, 33'h1_00D8_529E);

        v0 = 1'b1; a0 = 32'h5555_5555; b0 = 32'hAAAA_AAAA;
        txn("allones", 1'b0, 33'h0_FFFF_FFFF);

        // tie sequence from a fresh reset so the first grant goes to requester 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a0 = 32'd1; b0 = 32'd2; a1 = 32'd10; b1 = 32'd20;
        for (int k = 0; k < 4; k++) begin
`ifdef ADDER32_SCHED_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = (k % 2) != 0;
`endif
            v0 = 1'b1; v1 = 1'b1;
            #1;
            chk("tie_r0", {32'd0, r0}, {32'd0, ~exp_id});
            chk("tie_r1", {32'd0, r1}, {32'd0, exp_id});
            tick();
            chk("tie_calc_rdy", {31'd0, r0, r1}, 33'd0);
            tick();
            chk("tie_valid", {32'd0, rsp_valid}, 33'd1);
            chk("tie_id", {32'd0, rsp_id}, {32'd0, exp_id});
            chk("tie_sum", rsp_sum, exp_id ? 33'd30 : 33'd3);
            chk("tie_hold_rdy", {31'd0, r0, r1}, 33'd0);
            tick();
        end
        v0 = 1'b0; v1 = 1'b0;
        #1;

        rsp_ready = 1'b0;
        v0 = 1'b1; a0 = 32'h0000_0001; b0 = 32'hDEAF_BEEF;
        #1;
        chk("bp_r0", {32'd0, r0}, 33'd1);
        tick();
        tick();
        v0 = 1'b1; v1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_valid", {32'd0, rsp_valid}, 33'd1);
            chk("bp_sum", rsp_sum, 33'h0_DEAF_BEF0);
            chk("bp_id", {32'd0, rsp_id}, 33'd0);
            chk("bp_rdy", {31'd0, r0, r1}, 33'd0);
            tick();
        end
        v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b1;
        tick();
        chk("bp_release", {32'd0, rsp_valid}, 33'd0);

        // requester 0 was granted last here, so a surviving last-grant would favour 1
        v0 = 1'b1; a0 = 32'h0000_0005; b0 = 32'h0000_0007;
        #1;
        chk("abort_grant", {32'd0, r0}, 33'd1);
        tick();
        v0 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("abort_valid0", {32'd0, rsp_valid}, 33'd0);
        chk("abort_sum0", rsp_sum, 33'd0);
        tick();
        chk("abort_valid1", {32'd0, rsp_valid}, 33'd0);
        tick();
        chk("abort_valid2", {32'd0, rsp_valid}, 33'd0);

        v0 = 1'b1; v1 = 1'b1;
        a0 = 32'hFFFF_FFFF; b0 = 32'h0000_0001; a1 = 32'd4; b1 = 32'd4;
        txn("post_abort_tie", 1'b0, 33'h1_0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
